// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response handshake bundle between a requester and the data-memory responder
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_mem_op;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_write_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_read_data;
  logic                  resp_error;
  modport master (
    output req_valid, req_mem_op, req_address, req_write_data, resp_ready,
    input  req_ready, resp_valid, resp_read_data, resp_error
  );
  modport slave (
    input  req_valid, req_mem_op, req_address, req_write_data, resp_ready,
    output req_ready, resp_valid, resp_read_data, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding load/store responder with fixed access latency over word storage
module data_memory_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic clk,
  input logic reset,
  data_memory_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  accept, commit, done, oor;
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  always_comb begin
    accept  = state_q == IDLE && bus.req_valid && (bus.req_mem_op == 2'b01 || bus.req_mem_op == 2'b10);
    commit  = state_q == BUSY && cnt_q == 4'd0;
    done    = state_q == RESP && bus.resp_ready;
    oor     = (addr_q >> DEPTH_LOG2) != '0;
    state_d = accept ? BUSY : commit ? RESP : done ? IDLE : state_q;
    cnt_d   = accept ? 4'(LATENCY - 1) : (state_q == BUSY && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    wr_d    = accept ? bus.req_mem_op == 2'b10 : wr_q;
    addr_d  = accept ? bus.req_address : addr_q;
    wdata_d = accept ? bus.req_write_data : wdata_q;
    rdata_d = commit ? ((wr_q || oor) ? '0 : mem[addr_q[DEPTH_LOG2-1:0]]) : done ? '0 : rdata_q;
    err_d   = commit ? oor : done ? 1'b0 : err_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  // storage survives reset; a reset edge coinciding with commit must still block the write
  always_ff @(posedge clk) begin
    if (!reset && commit && wr_q && !oor) mem[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
  end
  assign bus.req_ready      = state_q == IDLE;
  assign bus.resp_valid     = state_q == RESP;
  assign bus.resp_read_data = rdata_q;
  assign bus.resp_error     = err_q;
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: table-driven and sequence checks of the responder at latencies 2, 3 and 1
module tb_data_memory_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  data_memory_responder_if ia(), ib(), ic();
  data_memory_responder #(.LATENCY(2)) ua (.clk(clk), .reset(rst_a), .bus(ia.slave));
  data_memory_responder #(.LATENCY(3)) ub (.clk(clk), .reset(rst_b), .bus(ib.slave));
  data_memory_responder #(.LATENCY(1)) uc (.clk(clk), .reset(rst_c), .bus(ic.slave));
  typedef struct {logic [31:0] d; logic e;} exp_t;
  typedef struct {logic [1:0] op; logic [15:0] a; logic [31:0] w; logic [31:0] d; logic e; int hold;} vec_t;
  exp_t sb[$];
  vec_t tbl[10];
  int checks = 0, errors = 0;
  time acc_t = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic idle(virtual data_memory_responder_if v);
    v.req_valid = 1'b0;
    v.req_mem_op = 2'b00;
    v.req_address = '0;
    v.req_write_data = '0;
    v.resp_ready = 1'b0;
  endtask
  task automatic chk_reset(input string n, virtual data_memory_responder_if v);
    chk({n, "_req_ready"}, 32'(v.req_ready), 1);
    chk({n, "_resp_valid"}, 32'(v.resp_valid), 0);
    chk({n, "_rdata"}, v.resp_read_data, 0);
    chk({n, "_err"}, 32'(v.resp_error), 0);
  endtask
  task automatic xact(virtual data_memory_responder_if v, input int lat, input logic [1:0] op,
                      input logic [15:0] a, input logic [31:0] w, input logic [31:0] d,
                      input logic e, input int hold);
    exp_t x;
    int n;
    v.req_valid = 1'b1;
    v.req_mem_op = op;
    v.req_address = a;
    v.req_write_data = w;
    v.resp_ready = hold == 0;
    chk("req_ready_idle", 32'(v.req_ready), 1);
    @(posedge clk);
    acc_t = $time;
    sb.push_back('{d, e});
    @(negedge clk);
    v.req_valid = 1'b0;
    v.req_mem_op = 2'b00;
    n = 0;
    while (!v.resp_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(lat));
    x = sb.pop_front();
    if (v.resp_valid) begin
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 32'(v.resp_valid), 1);
        chk("hold_data", v.resp_read_data, x.d);
        chk("hold_err", 32'(v.resp_error), 32'(x.e));
        chk("hold_req_ready", 32'(v.req_ready), 0);
        v.req_valid = 1'b1;
        v.req_mem_op = 2'b01;
        v.req_address = 16'h0001;
        @(posedge clk);
        @(negedge clk);
      end
      v.req_valid = 1'b0;
      v.req_mem_op = 2'b00;
      chk("resp_data", v.resp_read_data, x.d);
      chk("resp_err", 32'(v.resp_error), 32'(x.e));
      v.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("valid_drop", 32'(v.resp_valid), 0);
      chk("ready_back", 32'(v.req_ready), 1);
      chk("data_clear", v.resp_read_data, 0);
      chk("err_clear", 32'(v.resp_error), 0);
      v.resp_ready = 1'b0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] w;
    time p;
    tbl[0] = '{2'b10, 16'h0005, 32'hDEADBEEF, 32'h0, 1'b0, 0};
    tbl[1] = '{2'b01, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 0};
    tbl[2] = '{2'b01, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 4};
    tbl[3] = '{2'b10, 16'h0000, 32'h11110000, 32'h0, 1'b0, 0};
    tbl[4] = '{2'b10, 16'h0400, 32'h12345678, 32'h0, 1'b1, 0};
    tbl[5] = '{2'b01, 16'h0000, 32'h0, 32'h11110000, 1'b0, 0};
    tbl[6] = '{2'b01, 16'h0400, 32'h0, 32'h0, 1'b1, 2};
    tbl[7] = '{2'b10, 16'h03FF, 32'hA5A5A5A5, 32'h0, 1'b0, 0};
    tbl[8] = '{2'b01, 16'h03FF, 32'h0, 32'hA5A5A5A5, 1'b0, 0};
    tbl[9] = '{2'b01, 16'hFFFF, 32'h0, 32'h0, 1'b1, 0};
    idle(ia);
    idle(ib);
    idle(ic);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst_a", ia);
    chk_reset("rst_b", ib);
    chk_reset("rst_c", ic);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      xact(ia, 2, tbl[i].op, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].e, tbl[i].hold);
    for (int k = 0; k < 2; k++) begin
      ia.req_valid = 1'b1;
      ia.req_mem_op = k == 0 ? 2'b00 : 2'b11;
      ia.req_address = 16'h0005;
      ia.resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk("nop_req_ready", 32'(ia.req_ready), 1);
        chk("nop_resp_valid", 32'(ia.resp_valid), 0);
      end
    end
    idle(ia);
    xact(ia, 2, 2'b01, 16'h0005, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    xact(ib, 3, 2'b10, 16'h0007, 32'h0BADC0DE, 32'h0, 1'b0, 0);
    ib.req_valid = 1'b1;
    ib.req_mem_op = 2'b10;
    ib.req_address = 16'h0007;
    ib.req_write_data = 32'hCAFEF00D;
    ib.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle(ib);
    ib.resp_ready = 1'b1;
    @(posedge clk);
    #2 rst_b = 1'b1;
    #1 chk_reset("abort", ib);
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_no_resp", 32'(ib.resp_valid), 0);
    end
    ib.resp_ready = 1'b0;
    xact(ib, 3, 2'b01, 16'h0007, 32'h0, 32'h0BADC0DE, 1'b0, 0);
    p = 0;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      xact(ic, 1, 2'b10, 16'(i % 4), w, 32'h0, 1'b0, 0);
      if (i > 0) chk("pair_spacing", 32'(acc_t - p), 30);
      p = acc_t;
      xact(ic, 1, 2'b01, 16'(i % 4), 32'h0, w, 1'b0, 0);
      chk("stream_spacing", 32'(acc_t - p), 30);
      p = acc_t;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
